// File: rtl/cdc_src_buffer.sv
// Elastic FWFT buffer feeding the toggle-handshake CDC source port.
// Registered head word/valid, occupancy, almost-full and high-water status.
module cdc_src_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   high_water
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         high_water_q, high_water_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic push;
    logic pop;

    assign in_ready    = (count_q != DEPTH_C);
    assign push        = in_valid && in_ready && !flush && !rst;
    assign pop         = out_valid_q && out_ready && !flush;

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign count       = count_q;
    assign almost_full = (count_q >= AF_C);
    assign high_water  = high_water_q;

    always_comb begin
        // NOTE: every *_d gets a default first so no path infers a latch.
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        high_water_d = high_water_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        if (flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            high_water_d = '0;
            out_valid_d  = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            if (count_d > high_water_q) high_water_d = count_d;
            out_valid_d = (count_d != '0);

            // The next head is the word being written now only when nothing else remains stored.
            if (count_d != '0) begin
                if (push && ((count_q == '0) || (count_q == CW'(1) && pop)))
                    out_data_d = in_data;
                else
                    out_data_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            high_water_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            high_water_q <= high_water_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // NOTE: storage is deliberately not reset; only the registered head word is cleared.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

endmodule
